// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment pattern constants and types shared between the hex
// display driver and the receive-side count monitor.
// Patterns are active-low, bit0 = segment a ... bit6 = segment g.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [NIB_W-1:0] nibble_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_B     = 7'h03;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_D     = 7'h21;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_F     = 7'h0E;
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational pattern-to-nibble decoder.
// Ports:
//   seg       in   7-segment pattern (active-low)
//   hit_c     out  pattern is one of the 16 legal digits
//   blank_c   out  pattern is all segments off
//   nibble_c  out  decoded digit (0 when not a hit)
module seg7_decode
    import seg7_pkg::*;
(
    input  seg_t    seg,
    output logic    hit_c,
    output logic    blank_c,
    output nibble_t nibble_c
);

    // One case arm per legal pattern; anything else is blank or illegal.
    always_comb begin
        hit_c    = 1'b1;
        blank_c  = 1'b0;
        nibble_c = '0;
        case (seg)
            SEG_0:     nibble_c = 4'h0;
            SEG_1:     nibble_c = 4'h1;
            SEG_2:     nibble_c = 4'h2;
            SEG_3:     nibble_c = 4'h3;
            SEG_4:     nibble_c = 4'h4;
            SEG_5:     nibble_c = 4'h5;
            SEG_6:     nibble_c = 4'h6;
            SEG_7:     nibble_c = 4'h7;
            SEG_8:     nibble_c = 4'h8;
            SEG_9:     nibble_c = 4'h9;
            SEG_A:     nibble_c = 4'hA;
            SEG_B:     nibble_c = 4'hB;
            SEG_C:     nibble_c = 4'hC;
            SEG_D:     nibble_c = 4'hD;
            SEG_E:     nibble_c = 4'hE;
            SEG_F:     nibble_c = 4'hF;
            SEG_BLANK: begin
                hit_c   = 1'b0;
                blank_c = 1'b1;
            end
            default:   hit_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_count_monitor.sv
// seg7_count_monitor: watches an active-low 7-segment bus, accepts a pattern
// once it has been stable for STABLE_CYCLES samples, decodes it, and checks
// that successive digits count up by one modulo 16.
// Optional macro SEG7_MON_SYNC_EN: adds a 2-flop input synchronizer (reset to
// blank) ahead of the run tracker, adding 2 cycles of acceptance latency.
// Ports:
//   clock      in   sampling clock, rising edge
//   reset      in   asynchronous, active-low
//   seg_in     in   segment bus, active-low, bit0=a .. bit6=g
//   value      out  last accepted legal digit
//   valid      out  1-cycle pulse on legal digit acceptance
//   invalid    out  1-cycle pulse on illegal pattern acceptance
//   seq_err    out  1-cycle pulse on out-of-sequence digit while locked
//   locked     out  legal digit seen since reset / last illegal pattern
//   err_count  out  saturating count of invalid + seq_err events
module seg7_count_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  seg_t             seg_in,
    output nibble_t          value,
    output logic             valid,
    output logic             invalid,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    seg_t seg_s;

`ifdef SEG7_MON_SYNC_EN
    seg_t sync_q1;
    seg_t sync_q2;

    // Two-flop synchronizer for sources not timed to clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1 <= SEG_BLANK;
            sync_q2 <= SEG_BLANK;
        end else begin
            sync_q1 <= seg_in;
            sync_q2 <= sync_q1;
        end
    end

    assign seg_s = sync_q2;
`else
    assign seg_s = seg_in;
`endif

    // Run tracker state; tracked=0 means no pattern seen since reset.
    logic             tracked;
    seg_t             s_prev;
    logic [CNT_W-1:0] run_cnt;

    logic             new_run;
    logic [CNT_W-1:0] run_cnt_nxt;
    logic             accept;

    // Acceptance fires only on the edge where the count first reaches
    // STABLE, so a long steady run is accepted exactly once.
    always_comb begin
        new_run = !tracked || (seg_s != s_prev);
        if (new_run) begin
            run_cnt_nxt = CNT_W'(1);
        end else if (run_cnt == STABLE) begin
            run_cnt_nxt = run_cnt;
        end else begin
            run_cnt_nxt = run_cnt + CNT_W'(1);
        end
        accept = (run_cnt_nxt == STABLE) && (new_run || (run_cnt != STABLE));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tracked <= 1'b0;
            s_prev  <= SEG_BLANK;
            run_cnt <= '0;
        end else begin
            tracked <= 1'b1;
            s_prev  <= seg_s;
            run_cnt <= run_cnt_nxt;
        end
    end

    // Decode the sample being accepted (equals s_prev unless STABLE is 1).
    logic    dec_hit;
    logic    dec_blank;
    nibble_t dec_nibble;

    seg7_decode u_decode (
        .seg      (seg_s),
        .hit_c    (dec_hit),
        .blank_c  (dec_blank),
        .nibble_c (dec_nibble)
    );

    nibble_t          value_nxt;
    nibble_t          value_inc;
    logic             valid_nxt;
    logic             invalid_nxt;
    logic             seq_err_nxt;
    logic             locked_nxt;
    logic             err_inc;
    logic [ERR_W-1:0] err_count_nxt;

    // Acceptance handling: legal digit, blank (ignored), or illegal pattern.
    always_comb begin
        value_nxt   = value;
        valid_nxt   = 1'b0;
        invalid_nxt = 1'b0;
        seq_err_nxt = 1'b0;
        locked_nxt  = locked;
        err_inc     = 1'b0;
        value_inc   = value + 4'd1;

        if (accept) begin
            if (dec_hit) begin
                value_nxt  = dec_nibble;
                valid_nxt  = 1'b1;
                locked_nxt = 1'b1;
                if (locked && (dec_nibble != value_inc)) begin
                    seq_err_nxt = 1'b1;
                    err_inc     = 1'b1;
                end
            end else if (!dec_blank) begin
                invalid_nxt = 1'b1;
                locked_nxt  = 1'b0;
                err_inc     = 1'b1;
            end
        end

        if (err_inc && (err_count != '1)) begin
            err_count_nxt = err_count + ERR_W'(1);
        end else begin
            err_count_nxt = err_count;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value     <= '0;
            valid     <= 1'b0;
            invalid   <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            value     <= value_nxt;
            valid     <= valid_nxt;
            invalid   <= invalid_nxt;
            seq_err   <= seq_err_nxt;
            locked    <= locked_nxt;
            err_count <= err_count_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Directed bench for seg7_count_monitor (default build, STABLE_CYCLES=4).
// A second instance with ERR_W=2 shares the stimulus for the saturation case.
module tb_seg7_count_monitor;

    logic       clock;
    logic       reset;
    logic [6:0] seg_in;

    logic [3:0] value;
    logic       valid;
    logic       invalid;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    logic [3:0] value2;
    logic       valid2;
    logic       invalid2;
    logic       seq_err2;
    logic       locked2;
    logic [1:0] err_count2;

    int errors;
    int checks;
    int nvalid;
    int ninvalid;
    int nseq;
    logic last_valid;

    logic [6:0] digits [0:16];

    seg7_count_monitor #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .seg_in    (seg_in),
        .value     (value),
        .valid     (valid),
        .invalid   (invalid),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_count (err_count)
    );

    seg7_count_monitor #(.STABLE_CYCLES(4), .ERR_W(2)) dut_sat (
        .clock     (clock),
        .reset     (reset),
        .seg_in    (seg_in),
        .value     (value2),
        .valid     (valid2),
        .invalid   (invalid2),
        .seq_err   (seq_err2),
        .locked    (locked2),
        .err_count (err_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        nvalid   = 0;
        ninvalid = 0;
        nseq     = 0;
    endtask

    // Drive a pattern for n cycles, sampling outputs 1 time unit after each edge.
    task automatic hold(input logic [6:0] pat, input int n);
        seg_in = pat;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (valid)   nvalid++;
            if (invalid) ninvalid++;
            if (seq_err) nseq++;
            last_valid = valid;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        clear_counts();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_counts();
        last_valid = 1'b0;
        digits[0]  = 7'h40; digits[1]  = 7'h79; digits[2]  = 7'h24; digits[3]  = 7'h30;
        digits[4]  = 7'h19; digits[5]  = 7'h12; digits[6]  = 7'h02; digits[7]  = 7'h78;
        digits[8]  = 7'h00; digits[9]  = 7'h10; digits[10] = 7'h08; digits[11] = 7'h03;
        digits[12] = 7'h46; digits[13] = 7'h21; digits[14] = 7'h06; digits[15] = 7'h0E;
        digits[16] = 7'h40;

        // Reset state
        reset  = 1'b0;
        seg_in = 7'h7F;
        repeat (3) @(posedge clock);
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_invalid", 32'(invalid), 32'h0);
        check("rst_seq_err", 32'(seq_err), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        check("rst_err_count_sat", 32'(err_count2), 32'h0);
        reset = 1'b1;

        // Full count 0..F then wrap to 0, each held 4 cycles
        for (int d = 0; d < 17; d++) begin
            clear_counts();
            hold(digits[d], 4);
            check($sformatf("cnt_valid_%0d", d), 32'(nvalid), 32'd1);
            check($sformatf("cnt_pulse_last_%0d", d), 32'(last_valid), 32'd1);
            check($sformatf("cnt_value_%0d", d), 32'(value), 32'(d % 16));
            check($sformatf("cnt_seq_%0d", d), 32'(nseq), 32'd0);
            check($sformatf("cnt_locked_%0d", d), 32'(locked), 32'd1);
        end
        check("cnt_err_count", 32'(err_count), 32'h0);
        hold(7'h40, 2);
        check("cnt_pulse_once", 32'(valid), 32'h0);

        // Short run of 1 is ignored; 2 accepted
        do_reset();
        hold(7'h79, 3);
        check("short_no_accept", 32'(nvalid), 32'd0);
        check("short_not_locked", 32'(locked), 32'd0);
        hold(7'h24, 4);
        check("short_valid", 32'(nvalid), 32'd1);
        check("short_value", 32'(value), 32'h2);
        check("short_seq", 32'(nseq), 32'd0);

        // Glitch splits a run: 0 accepted again as a repeat -> seq_err
        do_reset();
        hold(7'h40, 4);
        check("glitch_first", 32'(nvalid), 32'd1);
        hold(7'h79, 1);
        hold(7'h40, 4);
        check("glitch_valid", 32'(nvalid), 32'd2);
        check("glitch_value", 32'(value), 32'h0);
        check("glitch_seq", 32'(nseq), 32'd1);
        check("glitch_err_count", 32'(err_count), 32'd1);
        check("glitch_locked", 32'(locked), 32'd1);

        // Reset mid-run of 2 after two samples
        clear_counts();
        hold(7'h24, 2);
        check("mid_no_accept", 32'(nvalid), 32'd0);
        #1;
        reset = 1'b0;
        #2;
        check("mid_async_value", 32'(value), 32'h0);
        check("mid_async_locked", 32'(locked), 32'h0);
        check("mid_async_err", 32'(err_count), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        clear_counts();
        hold(7'h24, 3);
        check("mid_no_pulse", 32'(nvalid), 32'd0);
        hold(7'h24, 1);
        check("mid_full_run", 32'(nvalid), 32'd1);
        check("mid_value", 32'(value), 32'h2);
        check("mid_seq", 32'(nseq), 32'd0);

        // Blank between digits is transparent to the sequence check
        do_reset();
        hold(7'h40, 4);
        hold(7'h79, 4);
        clear_counts();
        hold(7'h7F, 6);
        check("blank_no_valid", 32'(nvalid), 32'd0);
        check("blank_no_invalid", 32'(ninvalid), 32'd0);
        check("blank_value", 32'(value), 32'h1);
        check("blank_locked", 32'(locked), 32'd1);
        hold(7'h24, 4);
        check("blank_next_valid", 32'(nvalid), 32'd1);
        check("blank_next_value", 32'(value), 32'h2);
        check("blank_next_seq", 32'(nseq), 32'd0);
        check("blank_err_count", 32'(err_count), 32'd0);

        // Illegal pattern unlocks; next digit relocks without a sequence check
        do_reset();
        hold(7'h12, 4);
        check("ill_value5", 32'(value), 32'h5);
        clear_counts();
        hold(7'h55, 4);
        check("ill_invalid", 32'(ninvalid), 32'd1);
        check("ill_no_valid", 32'(nvalid), 32'd0);
        check("ill_locked", 32'(locked), 32'd0);
        check("ill_value_kept", 32'(value), 32'h5);
        check("ill_err_count", 32'(err_count), 32'd1);
        hold(7'h30, 4);
        check("ill_relock_valid", 32'(nvalid), 32'd1);
        check("ill_relock_value", 32'(value), 32'h3);
        check("ill_relock_seq", 32'(nseq), 32'd0);
        check("ill_relock_locked", 32'(locked), 32'd1);
        check("ill_relock_err", 32'(err_count), 32'd1);

        // Saturation: five illegal runs
        do_reset();
        hold(7'h55, 4);
        hold(7'h2A, 4);
        hold(7'h55, 4);
        check("sat_after3", 32'(err_count2), 32'd3);
        hold(7'h7E, 4);
        hold(7'h01, 4);
        check("sat_invalid_runs", 32'(ninvalid), 32'd5);
        check("sat_err_count_w8", 32'(err_count), 32'd5);
        check("sat_err_count_w2", 32'(err_count2), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
